// File: rtl/pe_cfg.sv
// pe_cfg: parametrised systolic-array processing element.
//   Mode 0: chain-sum PE (so = si + di*wi, operands forwarded east/south).
//   Mode 1: output-stationary PE (accumulate a LEN-term tile, emit once, then
//           pass neighbours' results along the drain chain).
// Optional feature macro: PE_CFG_SAT_EN -- when defined every accumulator add
// saturates and the sticky ovf flag is implemented; otherwise adds wrap and
// ovf is tied low.
module pe_cfg #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 24,
    parameter int unsigned CNT_W  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             valid_in,
    input  logic [DW-1:0]    di,
    input  logic [DW-1:0]    wi,
    input  logic [AW-1:0]    si,
    input  logic             si_valid,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [DW-1:0]    dout,
    output logic [DW-1:0]    wo,
    output logic             valid_out,
    output logic [AW-1:0]    so,
    output logic             so_valid,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

    state_e           state_q;
    logic             mode_q;
    logic [DW-1:0]    di_q, wi_q;
    logic             valid_q;
    logic [AW-1:0]    so_q;
    logic             so_valid_q;
    logic             busy_q;
    logic [AW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;

    logic [2*DW-1:0]  prod_w;
    logic [AW-1:0]    prod;
    logic [AW-1:0]    chain_term;
    logic [AW-1:0]    chain_add;
    logic [AW-1:0]    acc_add;

    logic             idle;
    logic             mode_eff;
    logic             chain_en;
    logic             tile_start;
    logic             acc_en;

    // Mode only takes effect in IDLE; a tile in flight keeps its captured mode.
    assign idle       = (state_q == StIdle);
    assign mode_eff   = idle ? mode : mode_q;
    assign chain_en   = idle && !mode_eff;
    assign tile_start = idle && mode_eff && start;
    assign acc_en     = (state_q == StAcc) && valid_q;

    // Product of the registered operands, extended to accumulator width.
    always_comb begin
        if (SIGNED) begin
            prod_w = {{DW{di_q[DW-1]}}, di_q} * {{DW{wi_q[DW-1]}}, wi_q};
            prod   = AW'($signed(prod_w));
        end else begin
            prod_w = {{DW{1'b0}}, di_q} * {{DW{1'b0}}, wi_q};
            prod   = AW'(prod_w);
        end
    end

    assign chain_term = valid_q ? prod : '0;

`ifdef PE_CFG_SAT_EN
    logic chain_clip;
    logic acc_clip;
    logic ovf_q;

    // Returns {clipped, result}; result pinned to the representable range.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0]   s;
        logic [AW-1:0] r;
        logic          clip;
        s    = {1'b0, a} + {1'b0, b};
        r    = s[AW-1:0];
        clip = 1'b0;
        if (SIGNED) begin
            if ((a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1])) begin
                clip = 1'b1;
                r    = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end
        end else if (s[AW]) begin
            clip = 1'b1;
            r    = '1;
        end
        return {clip, r};
    endfunction

    assign {chain_clip, chain_add} = sat_add(si, chain_term);
    assign {acc_clip, acc_add}     = sat_add(acc_q, prod);

    // Sticky overflow: any clip sets it, reset or an accepted start clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (tile_start) begin
            ovf_q <= 1'b0;
        end else if ((chain_en && chain_clip) || (acc_en && acc_clip)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign chain_add = si + chain_term;
    assign acc_add   = acc_q + prod;
    assign ovf       = 1'b0;
`endif

    // Operand stage: capture operands on valid, forward valid every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            di_q    <= '0;
            wi_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                di_q <= di;
                wi_q <= wi;
            end
        end
    end

    // Control FSM plus partial-sum / result output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            so_q       <= '0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    mode_q <= mode;
                    if (chain_en) begin
                        so_q       <= chain_add;
                        so_valid_q <= valid_q;
                    end else begin
                        so_q       <= si;
                        so_valid_q <= si_valid;
                        if (tile_start) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            len_q   <= len;
                            busy_q  <= 1'b1;
                            state_q <= (len == '0) ? StDrain : StAcc;
                        end
                    end
                end
                StAcc: begin
                    so_valid_q <= 1'b0;
                    if (acc_en) begin
                        acc_q <= acc_add;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((cnt_q + CNT_W'(1)) == len_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    so_q       <= acc_q;
                    so_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    so_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign dout      = di_q;
    assign wo        = wi_q;
    assign valid_out = valid_q;
    assign so        = so_q;
    assign so_valid  = so_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pe_cfg.sv
// Bench for pe_cfg: one unsigned and one signed instance driven in parallel,
// checked against a cycle-level arithmetic model of the chain and tile rules.
module tb_pe_cfg;

    localparam longint MASK = 64'hFFFFFF;
    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode, valid_in, si_valid, start;
    logic [7:0]  di, wi, len;
    logic [23:0] si;

    logic [7:0]  dout_u, wo_u, dout_s, wo_s;
    logic        valid_out_u, so_valid_u, busy_u, ovf_u;
    logic        valid_out_s, so_valid_s, busy_s, ovf_s;
    logic [23:0] so_u, so_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic        pv;
    logic [7:0]  pdi, pwi;
    logic [23:0] exp_so_u, exp_so_s;
    logic        exp_sov;
    bit          ovf_mu, ovf_ms, tile_active;

    always #5 clk = ~clk;

    pe_cfg #(.DW(8), .AW(24), .CNT_W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .mode(mode), .valid_in(valid_in), .di(di), .wi(wi),
        .si(si), .si_valid(si_valid), .start(start), .len(len),
        .dout(dout_u), .wo(wo_u), .valid_out(valid_out_u), .so(so_u),
        .so_valid(so_valid_u), .busy(busy_u), .ovf(ovf_u)
    );

    pe_cfg #(.DW(8), .AW(24), .CNT_W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .mode(mode), .valid_in(valid_in), .di(di), .wi(wi),
        .si(si), .si_valid(si_valid), .start(start), .len(len),
        .dout(dout_s), .wo(wo_s), .valid_out(valid_out_s), .so(so_s),
        .so_valid(so_valid_s), .busy(busy_s), .ovf(ovf_s)
    );

    function automatic longint sx8(input logic [7:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx24(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    // One clock: predict the chain-sum result for this edge, then advance.
    task automatic tick();
        longint su, ss;
        bit     live;
        live = rst && !tile_active && !mode;
        su = longint'(si) + (pv ? longint'(pdi) * longint'(pwi) : 0);
        ss = sx24(si) + (pv ? sx8(pdi) * sx8(pwi) : 0);
`ifdef PE_CFG_SAT_EN
        if (su > MASK) begin su = MASK; if (live) ovf_mu = 1; end
        if (ss > SMAX) begin ss = SMAX; if (live) ovf_ms = 1; end
        if (ss < SMIN) begin ss = SMIN; if (live) ovf_ms = 1; end
`endif
        exp_so_u = 24'(su & MASK);
        exp_so_s = 24'(ss & MASK);
        exp_sov  = pv;
        @(posedge clk);
        if (!rst) begin
            pv = 0; pdi = 0; pwi = 0; ovf_mu = 0; ovf_ms = 0; tile_active = 0;
        end else begin
            pv = valid_in;
            if (valid_in) begin pdi = di; pwi = wi; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 0; mode = 1; valid_in = 1; di = 8'hAA; wi = 8'h55; si = 24'h123456;
        si_valid = 1; start = 1; len = 8'd3;
        tick(); tick();
        n_tests++; if (so_u !== 24'h0 || so_s !== 24'h0) begin n_fail++;
            $display("FAIL reset_so got %h/%h want 000000", so_u, so_s); end
        n_tests++; if (so_valid_u !== 0 || valid_out_u !== 0) begin n_fail++;
            $display("FAIL reset_valid got so_valid=%b valid_out=%b want 0", so_valid_u, valid_out_u); end
        n_tests++; if (busy_u !== 0 || busy_s !== 0 || ovf_u !== 0) begin n_fail++;
            $display("FAIL reset_busy_ovf got busy=%b ovf=%b want 0", busy_u, ovf_u); end
        n_tests++; if (dout_u !== 8'h0 || wo_u !== 8'h0) begin n_fail++;
            $display("FAIL reset_fwd got %h/%h want 00", dout_u, wo_u); end
        rst = 1; mode = 0; valid_in = 0; di = 0; wi = 0; si = 0; si_valid = 0; start = 0; len = 0;
        tick();
    endtask

    task automatic test_chain_latency();
        mode = 0; valid_in = 1; di = 8'd3; wi = 8'd4; si = 24'd0;
        tick();
        n_tests++; if (so_valid_u !== 0) begin n_fail++;
            $display("FAIL t1_early got so_valid=%b want 0", so_valid_u); end
        n_tests++; if (dout_u !== 8'd3 || wo_u !== 8'd4 || valid_out_u !== 1) begin n_fail++;
            $display("FAIL t1_fwd got %0d/%0d/%b want 3/4/1", dout_u, wo_u, valid_out_u); end
        valid_in = 0; si = 24'd10;
        tick();
        n_tests++; if (so_u !== 24'd22 || so_valid_u !== 1) begin n_fail++;
            $display("FAIL t1_so got %0d v=%b want 22 v=1", so_u, so_valid_u); end
        tick();
        n_tests++; if (so_u !== 24'd10 || so_valid_u !== 0) begin n_fail++;
            $display("FAIL t1_after got %0d v=%b want 10 v=0", so_u, so_valid_u); end
    endtask

    task automatic test_signed();
        mode = 0; valid_in = 1; di = 8'hFD; wi = 8'd5; si = 24'd0;
        tick();
        valid_in = 0;
        tick();
        n_tests++; if (so_s !== 24'hFFFFF1) begin n_fail++;
            $display("FAIL t4_signed got %h want fffff1", so_s); end
        n_tests++; if (so_u !== 24'h0004F1) begin n_fail++;
            $display("FAIL t4_unsigned got %h want 0004f1", so_u); end
    endtask

    task automatic test_chain_random();
        for (int i = 0; i < 300; i++) begin
            mode = 0;
            valid_in = 1'($urandom_range(0, 1));
            di = 8'($urandom); wi = 8'($urandom);
            si = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFFFF - 24'($urandom_range(0, 70000)))
                                              : 24'($urandom);
            si_valid = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            len = 8'($urandom);
            tick();
            n_tests++; if (so_u !== exp_so_u || so_s !== exp_so_s) begin n_fail++;
                $display("FAIL chain_so[%0d] got %h/%h want %h/%h", i, so_u, so_s, exp_so_u, exp_so_s); end
            n_tests++; if (so_valid_u !== exp_sov || so_valid_s !== exp_sov) begin n_fail++;
                $display("FAIL chain_valid[%0d] got %b want %b", i, so_valid_u, exp_sov); end
            n_tests++; if (dout_u !== pdi || wo_u !== pwi || valid_out_u !== pv) begin n_fail++;
                $display("FAIL chain_fwd[%0d] got %h/%h/%b want %h/%h/%b", i, dout_u, wo_u,
                         valid_out_u, pdi, pwi, pv); end
            n_tests++; if (busy_u !== 0 || ovf_u !== ovf_mu || ovf_s !== ovf_ms) begin n_fail++;
                $display("FAIL chain_flags[%0d] got busy=%b ovf=%b/%b want 0 %b/%b", i, busy_u,
                         ovf_u, ovf_s, ovf_mu, ovf_ms); end
        end
        start = 0;
    endtask

    task automatic test_overflow();
        logic [23:0] want;
        logic        want_ovf;
`ifdef PE_CFG_SAT_EN
        want = 24'hFFFFFF; want_ovf = 1;
`else
        want = 24'h00FD01; want_ovf = 0;
`endif
        rst = 0; tick(); rst = 1;
        mode = 0; valid_in = 1; di = 8'd255; wi = 8'd255; si = 24'd0;
        tick();
        valid_in = 0; si = 24'hFFFF00;
        tick();
        n_tests++; if (so_u !== want || ovf_u !== want_ovf) begin n_fail++;
            $display("FAIL t3_so got %h ovf=%b want %h ovf=%b", so_u, ovf_u, want, want_ovf); end
        n_tests++; if (so_s !== 24'hFFFF01 || ovf_s !== 0) begin n_fail++;
            $display("FAIL t3_signed got %h ovf=%b want ffff01 ovf=0", so_s, ovf_s); end
        si = 24'd1;
        tick(); tick();
        n_tests++; if (ovf_u !== want_ovf || so_u !== 24'd1) begin n_fail++;
            $display("FAIL t3_sticky got ovf=%b so=%h want ovf=%b so=000001", ovf_u, so_u, want_ovf); end
    endtask

    task automatic test_tiles();
        for (int it = 0; it < 25; it++) begin
            int          n;
            longint      sum_u, sum_s;
            logic [7:0]  a, b;
            n = (it == 0) ? 4 : $urandom_range(1, 12);
            sum_u = 0; sum_s = 0;
            // operand valid on the start edge must not be accumulated
            mode = 1; si_valid = 0; start = 0; valid_in = 1; di = 8'($urandom); wi = 8'($urandom);
            tick();
            start = 1; len = 8'(n); valid_in = 0;
            tick();
            tile_active = 1; ovf_mu = 0; ovf_ms = 0;
            n_tests++; if (busy_u !== 1 || busy_s !== 1) begin n_fail++;
                $display("FAIL tile_busy_on[%0d] got %b/%b want 1", it, busy_u, busy_s); end
            start = 0;
            for (int k = 0; k < n; k++) begin
                int g;
                g = (it == 0) ? 0 : $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    valid_in = 0; di = 8'($urandom); wi = 8'($urandom);
                    start = ($urandom_range(0, 3) == 0); len = 8'($urandom_range(0, 3));
                    mode = 1'($urandom_range(0, 1));
                    si = 24'($urandom); si_valid = 1'($urandom_range(0, 1));
                    tick();
                    n_tests++; if (busy_u !== 1 || so_valid_u !== 0 || so_valid_s !== 0) begin
                        n_fail++;
                        $display("FAIL tile_gap[%0d] got busy=%b so_valid=%b want 1/0", it, busy_u,
                                 so_valid_u); end
                end
                if (it == 0) begin
                    a = 8'(2 * k + 1); b = 8'(2 * k + 2);
                    start = 0; mode = 1; si_valid = 0;
                end else begin
                    a = 8'($urandom); b = 8'($urandom);
                    start = ($urandom_range(0, 3) == 0); len = 8'($urandom_range(0, 3));
                    mode = 1'($urandom_range(0, 1));
                    si = 24'($urandom); si_valid = 1'($urandom_range(0, 1));
                end
                valid_in = 1; di = a; wi = b;
                sum_u += longint'(a) * longint'(b);
                sum_s += sx8(a) * sx8(b);
                tick();
                n_tests++; if (busy_u !== 1 || so_valid_u !== 0 || so_valid_s !== 0) begin
                    n_fail++;
                    $display("FAIL tile_acc[%0d] got busy=%b so_valid=%b want 1/0", it, busy_u,
                             so_valid_u); end
            end
            valid_in = 0; start = 0; mode = 1; si_valid = 0; si = 0;
            tick();
            n_tests++; if (busy_u !== 1 || so_valid_u !== 0) begin n_fail++;
                $display("FAIL tile_predrain[%0d] got busy=%b so_valid=%b want 1/0", it, busy_u,
                         so_valid_u); end
            tick();
            tile_active = 0;
            n_tests++; if (so_valid_u !== 1 || so_valid_s !== 1 || busy_u !== 0) begin n_fail++;
                $display("FAIL tile_pulse[%0d] got so_valid=%b busy=%b want 1/0", it, so_valid_u,
                         busy_u); end
            n_tests++; if (so_u !== 24'(sum_u & MASK) || so_s !== 24'(sum_s & MASK)) begin
                n_fail++;
                $display("FAIL tile_sum[%0d] got %h/%h want %h/%h", it, so_u, so_s,
                         24'(sum_u & MASK), 24'(sum_s & MASK)); end
            n_tests++; if (ovf_u !== ovf_mu || ovf_s !== ovf_ms) begin n_fail++;
                $display("FAIL tile_ovf[%0d] got %b/%b want %b/%b", it, ovf_u, ovf_s, ovf_mu,
                         ovf_ms); end
            tick();
            n_tests++; if (so_valid_u !== 0 || busy_u !== 0) begin n_fail++;
                $display("FAIL tile_single[%0d] got so_valid=%b busy=%b want 0/0", it, so_valid_u,
                         busy_u); end
        end
    endtask

    task automatic test_len_zero();
        mode = 1; start = 1; len = 8'd0; valid_in = 1; di = 8'd7; wi = 8'd9; si_valid = 0;
        tick();
        n_tests++; if (busy_u !== 1 || so_valid_u !== 0) begin n_fail++;
            $display("FAIL len0_busy got busy=%b so_valid=%b want 1/0", busy_u, so_valid_u); end
        start = 0; valid_in = 0;
        tick();
        n_tests++; if (so_valid_u !== 1 || so_u !== 24'd0 || busy_u !== 0) begin n_fail++;
            $display("FAIL len0_drain got so=%h v=%b busy=%b want 000000 1 0", so_u, so_valid_u,
                     busy_u); end
    endtask

    task automatic test_reset_mid();
        mode = 1; start = 1; len = 8'd4; valid_in = 0; si_valid = 0;
        tick();
        tile_active = 1; start = 0;
        valid_in = 1; di = 8'd1; wi = 8'd1; tick();
        di = 8'd2; wi = 8'd2; tick();
        di = 8'd3; wi = 8'd3; tick();
        rst = 0; tick();
        n_tests++; if (busy_u !== 0 || busy_s !== 0 || so_u !== 24'd0 || so_valid_u !== 0) begin
            n_fail++;
            $display("FAIL t5_abort got busy=%b so=%h v=%b want 0 000000 0", busy_u, so_u,
                     so_valid_u); end
        rst = 1; valid_in = 0;
        tick();
        n_tests++; if (so_valid_u !== 0 || valid_out_u !== 0) begin n_fail++;
            $display("FAIL t5_nopulse got so_valid=%b valid_out=%b want 0", so_valid_u,
                     valid_out_u); end
        mode = 1; start = 1; len = 8'd1;
        tick();
        tile_active = 1; start = 0;
        valid_in = 1; di = 8'd2; wi = 8'd3; tick();
        valid_in = 0; tick(); tick();
        tile_active = 0;
        n_tests++; if (so_u !== 24'd6 || so_s !== 24'd6 || so_valid_u !== 1) begin n_fail++;
            $display("FAIL t5_fresh got %0d/%0d v=%b want 6 v=1", so_u, so_s, so_valid_u); end
    endtask

    task automatic test_drain_chain();
        mode = 1; start = 0; valid_in = 0; si = 24'h000123; si_valid = 1;
        tick();
        n_tests++; if (so_u !== 24'h000123 || so_s !== 24'h000123 || so_valid_u !== 1) begin
            n_fail++;
            $display("FAIL t6_drain got %h v=%b want 000123 v=1", so_u, so_valid_u); end
        for (int i = 0; i < 8; i++) begin
            si = 24'($urandom); si_valid = 1'($urandom_range(0, 1));
            tick();
            n_tests++; if (so_u !== si || so_valid_u !== si_valid) begin n_fail++;
                $display("FAIL drain_rand[%0d] got %h v=%b want %h v=%b", i, so_u, so_valid_u, si,
                         si_valid); end
        end
        // second start inside a tile must not restart it
        si_valid = 0; start = 1; len = 8'd3;
        tick();
        tile_active = 1; start = 0;
        valid_in = 1; di = 8'd1; wi = 8'd1; tick();
        start = 1; len = 8'd1; di = 8'd2; wi = 8'd2; tick();
        start = 0; di = 8'd3; wi = 8'd3; tick();
        valid_in = 0; tick();
        n_tests++; if (busy_u !== 1 || so_valid_u !== 0) begin n_fail++;
            $display("FAIL t6_midstart got busy=%b v=%b want 1/0", busy_u, so_valid_u); end
        tick();
        tile_active = 0;
        n_tests++; if (so_u !== 24'd14 || so_valid_u !== 1) begin n_fail++;
            $display("FAIL t6_ignored_start got %0d v=%b want 14 v=1", so_u, so_valid_u); end
    endtask

    initial begin
        pv = 0; pdi = 0; pwi = 0; ovf_mu = 0; ovf_ms = 0; tile_active = 0;
        exp_so_u = 0; exp_so_s = 0; exp_sov = 0;
        test_reset();
        test_chain_latency();
        test_signed();
        test_chain_random();
        test_overflow();
        test_tiles();
        test_len_zero();
        test_reset_mid();
        test_drain_chain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
